key_step_decoder: RTL and testbench

KEY_STEP_DECODER -- requirements
Module: key_step_decoder

---
 rtl/key_step_decoder_if.sv | 35 +++
 rtl/key_step_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_key_step_decoder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/key_step_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : key_step_decoder_if
// Description : PS/2 line inputs and decoded step/error outputs of the
//               key_step_decoder, bundled as one interface. The master side
//               drives the keyboard lines; the slave side is the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_step_decoder_if;
    logic ps2_clk;
    logic ps2_data;
    logic stepleft;
    logic stepright;
    logic stepjump;
    logic frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  stepleft,
        input  stepright,
        input  stepjump,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output stepleft,
        output stepright,
        output stepjump,
        output frame_err
    );
endinterface
`default_nettype wire

// File: rtl/key_step_decoder.sv
`default_nettype none
// ============================================================================
// Module      : key_step_decoder
// Description : PS/2 keyboard receiver that turns A / D / Space scan codes
//               into held-level step outputs (left / right / jump), with a
//               one-cycle frame_err pulse on malformed or timed-out frames.
//               Optional macro ARROW_KEYS_EN adds E0-prefixed arrow keys
//               (6B left, 74 right, 75 jump) alongside the letter keys.
// Revision    : 1.0 - initial release
// ============================================================================
module key_step_decoder #(
    parameter int TIMEOUT_CYC = 65000,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    key_step_decoder_if.slave bus
);

    localparam int                     c_TIMER_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TIMER_W-1:0]   c_TIMEOUT = c_TIMER_W'(TIMEOUT_CYC);
    localparam logic [7:0]             c_BRK     = 8'hF0;
    localparam logic [7:0]             c_EXT     = 8'hE0;
    localparam logic [7:0]             c_KEY_A   = 8'h1C;
    localparam logic [7:0]             c_KEY_D   = 8'h23;
    localparam logic [7:0]             c_KEY_SP  = 8'h29;
`ifdef ARROW_KEYS_EN
    localparam logic [7:0]             c_KEY_LT  = 8'h6B;
    localparam logic [7:0]             c_KEY_RT  = 8'h74;
    localparam logic [7:0]             c_KEY_UP  = 8'h75;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Line synchronizers
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic                   w_fall;
    logic                   w_bit;

    // Idle level of the PS/2 lines is 1, so preset high to avoid a fake edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], bus.ps2_data};
            r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
    assign w_bit  = r_data_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------------
    state_t                 r_state, w_state_nxt;
    logic [2:0]             r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]             r_shift, w_shift_nxt;
    logic [c_TIMER_W-1:0]   r_timer, w_timer_nxt;
    logic                   r_byte_valid, w_byte_valid_nxt;
    logic                   r_rx_err, w_rx_err_nxt;

    // Receiver state and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_timer      <= '0;
            r_byte_valid <= 1'b0;
            r_rx_err     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_timer      <= w_timer_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_rx_err     <= w_rx_err_nxt;
        end
    end

    // Next-state logic: one bit per synchronized falling edge, plus the
    // inactivity timeout that abandons a half-received frame.
    always_comb begin
        w_state_nxt      = r_state;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_byte_valid_nxt = 1'b0;
        w_rx_err_nxt     = 1'b0;

        if (r_state == IDLE || w_fall) begin
            w_timer_nxt = '0;
        end else if (r_timer != c_TIMEOUT) begin
            w_timer_nxt = r_timer + 1'b1;
        end else begin
            w_timer_nxt = r_timer;
        end

        if (r_state != IDLE && !w_fall && r_timer == c_TIMEOUT) begin
            w_state_nxt  = IDLE;
            w_rx_err_nxt = 1'b1;
            w_timer_nxt  = '0;
        end else if (w_fall) begin
            case (r_state)
                IDLE: begin
                    // A high start bit is line noise, not a frame.
                    if (!w_bit) begin
                        w_state_nxt   = DATA;
                        w_bit_cnt_nxt = '0;
                    end
                end
                DATA: begin
                    w_shift_nxt = {w_bit, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = PARITY;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    // Odd parity: data plus parity bit must hold an odd count.
                    if ((^r_shift) ^ w_bit) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_state_nxt  = IDLE;
                        w_rx_err_nxt = 1'b1;
                    end
                end
                STOP: begin
                    w_state_nxt = IDLE;
                    if (w_bit) begin
                        w_byte_valid_nxt = 1'b1;
                    end else begin
                        w_rx_err_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Scan-code decoder
    // ------------------------------------------------------------------------
    logic r_brk;
    logic r_ext;
    logic r_stepleft;
    logic r_stepright;
    logic r_stepjump;

    // Track F0/E0 prefixes and set/clear the held-key levels; a repeat make
    // code rewrites the same value, so typematic repeats are invisible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_brk       <= 1'b0;
            r_ext       <= 1'b0;
            r_stepleft  <= 1'b0;
            r_stepright <= 1'b0;
            r_stepjump  <= 1'b0;
        end else if (r_rx_err) begin
            r_brk <= 1'b0;
            r_ext <= 1'b0;
        end else if (r_byte_valid) begin
            if (r_shift == c_BRK) begin
                r_brk <= 1'b1;
            end else if (r_shift == c_EXT) begin
                r_ext <= 1'b1;
            end else begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
                if (!r_ext) begin
                    case (r_shift)
                        c_KEY_A:  r_stepleft  <= ~r_brk;
                        c_KEY_D:  r_stepright <= ~r_brk;
                        c_KEY_SP: r_stepjump  <= ~r_brk;
                        default:  ;
                    endcase
                end
`ifdef ARROW_KEYS_EN
                else begin
                    case (r_shift)
                        c_KEY_LT: r_stepleft  <= ~r_brk;
                        c_KEY_RT: r_stepright <= ~r_brk;
                        c_KEY_UP: r_stepjump  <= ~r_brk;
                        default:  ;
                    endcase
                end
`endif
            end
        end
    end

    assign bus.stepleft  = r_stepleft;
    assign bus.stepright = r_stepright;
    assign bus.stepjump  = r_stepjump;
    assign bus.frame_err = r_rx_err;

endmodule
`default_nettype wire

// File: tb/tb_key_step_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_step_decoder
// Description : Scoreboard bench for key_step_decoder. Stimulus pushes the
//               expected {frame_err, left, right, jump} word for every frame
//               that should change the outputs; a negedge monitor pops one
//               entry each time the outputs change or frame_err pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_step_decoder;

    localparam int c_TIMEOUT = 300;
    localparam int c_SYNC    = 2;
    localparam int c_HALF    = 10;
    localparam int c_LAT     = c_SYNC + 2;

    typedef struct {
        logic [3:0] v;
        int         t0;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    bit   mon_en;
    logic [2:0] prev;
    exp_t sb[$];

    key_step_decoder_if bus ();

    key_step_decoder #(
        .TIMEOUT_CYC (c_TIMEOUT),
        .SYNC_STAGES (c_SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output change or error pulse consumes one expectation.
    always @(negedge clk) begin
        logic [2:0] cur;
        exp_t       e;
        cur = {bus.stepleft, bus.stepright, bus.stepjump};
        if (mon_en && (bus.frame_err !== 1'b0 || cur !== prev)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got=%b%b cyc=%0d", bus.frame_err, cur, cyc);
            end else begin
                e = sb.pop_front();
                if ({bus.frame_err, cur} !== e.v) begin
                    errors++;
                    $display("FAIL event got=%b%b want=%b cyc=%0d", bus.frame_err, cur, e.v, cyc);
                end
                if (e.t0 >= 0) begin
                    checks++;
                    if (cyc - e.t0 != c_LAT) begin
                        errors++;
                        $display("FAIL latency got=%0d want=%0d", cyc - e.t0, c_LAT);
                    end
                end
            end
            prev = cur;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] v, input int t0);
        exp_t e;
        e.v  = v;
        e.t0 = t0;
        sb.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [3:0] want);
        checks++;
        if ({bus.frame_err, bus.stepleft, bus.stepright, bus.stepjump} !== want) begin
            errors++;
            $display("FAIL %s got=%b%b%b%b want=%b", name, bus.frame_err, bus.stepleft,
                     bus.stepright, bus.stepjump, want);
        end
    endtask

    // Drive the first nbits of a PS/2 frame; the expected word (if any) is
    // queued at the stop-bit falling edge so its latency can be measured.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                              input bit has_exp, input logic [3:0] v);
        logic [10:0] f;
        f = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = f[i];
            tick(c_HALF);
            bus.ps2_clk = 1'b0;
            if (i == 10 && has_exp) push_exp(v, cyc);
            tick(c_HALF);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
        tick(2 * c_HALF);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit has_exp, input logic [3:0] v);
        send_frame(b, 1'b0, 11, has_exp, v);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        mon_en       = 1'b0;
        prev         = 3'b000;
        rst          = 1'b0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        tick(3);
        check_now("reset_state", 4'b0000);
        rst = 1'b1;
        tick(3);
        check_now("after_release", 4'b0000);
        mon_en = 1'b1;

        // Left press and release.
        send_byte(8'h1C, 1, 4'b0100);
        send_byte(8'hF0, 0, 4'b0000);
        send_byte(8'h1C, 1, 4'b0000);

        // Right and jump together, then right released.
        send_byte(8'h23, 1, 4'b0010);
        send_byte(8'h29, 1, 4'b0011);
        send_byte(8'hF0, 0, 4'b0000);
        send_byte(8'h23, 1, 4'b0001);
        send_byte(8'hF0, 0, 4'b0000);
        send_byte(8'h29, 1, 4'b0000);

        // Bad parity: error pulse only, then a good frame still decodes.
        push_exp(4'b1000, -1);
        send_frame(8'h1C, 1'b1, 11, 0, 4'b0000);
        check_now("after_parity_err", 4'b0000);
        send_byte(8'h1C, 1, 4'b0100);
        send_byte(8'hF0, 0, 4'b0000);
        send_byte(8'h1C, 1, 4'b0000);

        // Truncated frame followed by a long idle gap.
        push_exp(4'b1000, -1);
        send_frame(8'h29, 1'b0, 5, 0, 4'b0000);
        tick(c_TIMEOUT + 10);
        send_byte(8'h29, 1, 4'b0001);
        send_byte(8'hF0, 0, 4'b0000);
        send_byte(8'h29, 1, 4'b0000);

        // Break of an unheld key and an unmapped key: no change.
        send_byte(8'hF0, 0, 4'b0000);
        send_byte(8'h29, 0, 4'b0000);
        send_byte(8'h15, 0, 4'b0000);

        // Extended left arrow.
`ifdef ARROW_KEYS_EN
        send_byte(8'hE0, 0, 4'b0000);
        send_byte(8'h6B, 1, 4'b0100);
        check_now("arrow_left", 4'b0100);
        send_byte(8'hE0, 0, 4'b0000);
        send_byte(8'hF0, 0, 4'b0000);
        send_byte(8'h6B, 1, 4'b0000);
`else
        send_byte(8'hE0, 0, 4'b0000);
        send_byte(8'h6B, 0, 4'b0000);
        check_now("arrow_ignored", 4'b0000);
`endif

        // Typematic repeat, then left and right held together.
        send_byte(8'h1C, 1, 4'b0100);
        send_byte(8'h1C, 0, 4'b0000);
        send_byte(8'h23, 1, 4'b0110);
        check_now("left_and_right", 4'b0110);
        send_byte(8'hF0, 0, 4'b0000);
        send_byte(8'h1C, 1, 4'b0010);
        send_byte(8'hF0, 0, 4'b0000);
        send_byte(8'h23, 1, 4'b0000);

        // Reset in the middle of a frame.
        send_byte(8'h23, 1, 4'b0010);
        push_exp(4'b0000, -1);
        send_frame(8'h1C, 1'b0, 4, 0, 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_now("in_reset", 4'b0000);
        end
        rst = 1'b1;
        tick(2);
        send_byte(8'h23, 1, 4'b0010);
        check_now("after_mid_reset", 4'b0010);

        tick(50);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_events got=%0d want=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
